multiword_add_sequencer: RTL
============================

// Module: multiword_add_sequencer
// PURPOSE
//   Multi-precision adder controller: adds two W=N*K-bit operands through one shared N-bit
//   CarryLookAheadAdder instance, one N-bit slice per clock, LSB slice first.
//   Carry-out of each slice is registered and fed back as the next slice's carry-in.
//   Valid/ready handshakes on input and output; sits between the ALU operand regs and result bus.
// PARAMETERS
//   N  8  slice width; also the width of the instantiated CarryLookAheadAdder
//   K  4  number of slices (K>=2); operand width W=N*K
// PORTS
//   clk        in   1    single clock, all state updates on rising edge
//   rst        in   1    synchronous, active-high reset
//   in_valid   in   1    operands presented
//   in_ready   out  1    block accepts operands (IDLE and rst low)
//   a          in   W    operand A
//   b          in   W    operand B
//   cin        in   1    initial carry-in
//   out_valid  out  1    result available (DONE)
//   out_ready  in   1    consumer takes result
//   sum        out  W    registered result
//   cout       out  1    registered final carry-out
//   busy       out  1    state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, out_valid=0, sum=0, cout=0, busy=0, slice idx=0, carry reg=0.
//     in_ready=0 while rst high.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid&in_ready, latch a, b into operand regs, carry<=cin, idx<=0; go RUN.
//     No accept otherwise.
//   - RUN, one slice per cycle:
//     - adder A=a_reg[idx*N+:N], B=b_reg[idx*N+:N], Cin=carry.
//     - acc[idx*N+:N]<=Sum; carry<=Cout; idx<=idx+1.
//     - Idle-state inputs ignored.
//   - Completion: on the RUN cycle with idx==K-1, sum<={Sum,acc lower slices}, cout<=Cout,
//     idx wraps to 0; go DONE.
//   - Latency: out_valid rises exactly K cycles after the accept edge.
//   - DONE: out_valid=1; sum/cout held stable. On out_valid&out_ready go IDLE, out_valid<=0.
//     No accept in DONE.
//   - Min issue period: K+2 cycles per operation.
//   - sum/cout change only on entry to DONE or on reset; they keep the last result in IDLE/RUN.
//   - in_valid during RUN/DONE: ignored, not queued. Operand changes after accept have no effect.
//   - Reset mid-RUN or mid-DONE: partial/undelivered result discarded, next cycle in IDLE with reset values.
//   - Arithmetic is modulo 2^W; cout is bit W of a+b+cin.
// CONFIGURATION
//   ADDSEQ_SUB_EN defined:
//     - Adds input port `sub` (1 bit), latched with operands on accept.
//     - sub=1: b_reg loaded as ~b, initial carry forced to 1 (cin ignored); result = a-b mod 2^W,
//       cout=1 means no borrow (a>=b unsigned).
//     - sub=0: identical to the undefined build.
//   ADDSEQ_SUB_EN undefined: no `sub` port; always a+b+cin.
// TESTING (N=8, K=4)
//   1. a=0x00000001, b=0xFFFFFFFF, cin=0
//      -> 4 cycles after accept: out_valid=1, sum=0x00000000, cout=1 (carry ripples through all slices).
//   2. a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0, busy high for the whole op.
//   3. Case 2, then hold out_ready=0 for 5 cycles with in_valid=1
//      -> out_valid, sum, cout stable; in_ready=0; no new accept; after out_ready=1, IDLE next cycle.
//   4. Start a=0xFFFFFFFF, b=1; assert rst after 2 RUN cycles
//      -> next cycle state IDLE, out_valid=0, sum=0, cout=0; then 3+4 -> sum=7.
//   5. in_valid held 1, out_ready held 1, three ops -> accepts exactly every 6 cycles; results in order.
//   6. [ADDSEQ_SUB_EN] 5-7 -> sum=0xFFFFFFFE, cout=0; 7-5 -> sum=0x00000002, cout=1; cin ignored in both.

Source files
------------

// File: rtl/multiword_add_sequencer_if.sv
// Operand/result handshake bundle for multiword_add_sequencer.
// ADDSEQ_SUB_EN adds the `sub` operand-side control bit.
interface multiword_add_sequencer_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef ADDSEQ_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
`ifdef ADDSEQ_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
`ifdef ADDSEQ_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder: K slices of N bits through one shared carry-lookahead adder, LSB first.
// Optional feature macro ADDSEQ_SUB_EN: adds `sub` to compute a-b via ~b and forced carry-in.

module CarryLookAheadAdder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         pp;

    // Each carry is a flat OR of generate terms gated by propagate prefixes.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        c  = '0;
        pp = 1'b0;
        c[0] = cin_i;
        for (int i = 0; i < int'(N); i++) begin
            c[i+1] = g[i];
            pp     = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & g[j]);
                pp     = pp & p[j];
            end
            c[i+1] = c[i+1] | (pp & cin_i);
        end
    end

    assign sum_o  = p ^ c[N-1:0];
    assign cout_o = c[N];
endmodule

module multiword_add_sequencer #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    multiword_add_sequencer_if.slave  bus,
    output logic                      busy
);
    localparam int unsigned W     = N * K;
    localparam int unsigned LOW_W = W - N;
    localparam int unsigned IW    = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LOW_W-1:0] acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;

    logic            in_ready_c;
    logic            out_valid_c;
    logic            busy_c;
    logic            accept_c;

    logic [N-1:0]    slice_a;
    logic [N-1:0]    slice_b;
    logic [N-1:0]    slice_sum;
    logic            slice_cout;

    assign slice_a = a_q[idx_q*N +: N];
    assign slice_b = b_q[idx_q*N +: N];

    CarryLookAheadAdder #(.N(N)) u_cla (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    assign accept_c = bus.in_valid & in_ready_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake/status decode; in_ready is held low for the whole reset cycle
    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        unique case (state_q)
            IDLE: in_ready_c = ~rst;
            RUN:  busy_c     = 1'b1;
            DONE: begin
                out_valid_c = 1'b1;
                busy_c      = 1'b1;
            end
            default: busy_c = 1'b1;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign busy          = busy_c;

    // Datapath next-state: operand capture, slice accumulation, result commit
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    a_d   = bus.a;
`ifdef ADDSEQ_SUB_EN
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
`else
                    b_d     = bus.b;
                    carry_d = bus.cin;
`endif
                    idx_d = '0;
                end
            end
            RUN: begin
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    sum_d  = {slice_sum, acc_q};
                    cout_d = slice_cout;
                    idx_d  = '0;
                end else begin
                    acc_d[idx_q*N +: N] = slice_sum;
                    idx_d = idx_q + IW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
endmodule
